// File: rtl/pds_pkg.sv
// Shared field widths, packet type and counter helper for the PDS receive path.
package pds_pkg;

  localparam int PDS_SRC_W  = 4;
  localparam int PDS_TGT_W  = 4;
  localparam int PDS_DATA_W = 8;
  localparam int PDS_WORD_W = 16;
  localparam int PDS_CNT_W  = 16;

  // Field order matches the wire word {source, target, data}
  typedef struct packed {
    logic [PDS_SRC_W-1:0]  source;
    logic [PDS_TGT_W-1:0]  target;
    logic [PDS_DATA_W-1:0] data;
  } pds_pkt_t;

  function automatic logic [PDS_CNT_W-1:0] sat_inc(input logic [PDS_CNT_W-1:0] cnt);
    if (cnt == {PDS_CNT_W{1'b1}}) begin
      return cnt;
    end else begin
      return cnt + PDS_CNT_W'(1'b1);
    end
  endfunction

endpackage

// File: rtl/pds_rx_if.sv
// PDS receive bus: link-side word/strobe, downstream stream and status.
// filt_cnt exists only when PDS_RX_FILTER_EN is defined.
interface pds_rx_if
  import pds_pkg::*;
#(
  parameter int DEPTH = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [PDS_WORD_W-1:0] data_ip;
  logic                  valid_up;
  logic                  out_valid;
  logic                  out_ready;
  logic [PDS_SRC_W-1:0]  out_source;
  logic [PDS_TGT_W-1:0]  out_target;
  logic [PDS_DATA_W-1:0] out_data;
  logic [LVL_W-1:0]      level;
  logic                  full;
  logic                  empty;
  logic [PDS_CNT_W-1:0]  drop_cnt;
`ifdef PDS_RX_FILTER_EN
  logic [PDS_CNT_W-1:0]  filt_cnt;

  modport master (
    output data_ip, valid_up, out_ready,
    input  out_valid, out_source, out_target, out_data, level, full, empty, drop_cnt, filt_cnt
  );
  modport slave (
    input  data_ip, valid_up, out_ready,
    output out_valid, out_source, out_target, out_data, level, full, empty, drop_cnt, filt_cnt
  );
`else
  modport master (
    output data_ip, valid_up, out_ready,
    input  out_valid, out_source, out_target, out_data, level, full, empty, drop_cnt
  );
  modport slave (
    input  data_ip, valid_up, out_ready,
    output out_valid, out_source, out_target, out_data, level, full, empty, drop_cnt
  );
`endif

endinterface

// File: rtl/pds_fifo.sv
// Synchronous packet FIFO with registered head entry, level and flags.
module pds_fifo
  import pds_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  pds_pkt_t      din,
  output pds_pkt_t      dout,
  output logic          valid,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [AW-1:0] rd_ptr_r, wr_ptr_r;
  pds_pkt_t      mem_r [DEPTH];
  pds_pkt_t      dout_r, head_nx_s;
  logic [LW-1:0] level_r, level_nx_s, remain_s;
  logic          valid_r, full_r, empty_r;
  logic          push_ok_s, pop_ok_s;

  // Accept/remove decisions, next occupancy and the entry that will be at the head
  always_comb begin
    pop_ok_s  = pop & valid_r;
    push_ok_s = push & (~full_r | pop_ok_s);
    remain_s  = level_r - LW'(pop_ok_s);
    if (push_ok_s && !pop_ok_s) begin
      level_nx_s = level_r + LW'(1'b1);
    end else if (pop_ok_s && !push_ok_s) begin
      level_nx_s = level_r - LW'(1'b1);
    end else begin
      level_nx_s = level_r;
    end
    // An empty-after-pop FIFO takes its head straight from the incoming word
    if (remain_s != {LW{1'b0}}) begin
      head_nx_s = mem_r[rd_ptr_r + AW'(pop_ok_s)];
    end else if (push_ok_s) begin
      head_nx_s = din;
    end else begin
      head_nx_s = dout_r;
    end
  end

  // Storage array; contents are qualified by the occupancy count so need no reset
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy, flags and registered head
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
      valid_r  <= 1'b0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      dout_r   <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      level_r <= level_nx_s;
      valid_r <= (level_nx_s != {LW{1'b0}});
      full_r  <= (level_nx_s == LW'(DEPTH));
      empty_r <= (level_nx_s == {LW{1'b0}});
      dout_r  <= head_nx_s;
    end
  end

  assign dout  = dout_r;
  assign valid = valid_r;
  assign level = level_r;
  assign full  = full_r;
  assign empty = empty_r;

endmodule

// File: rtl/pds_rx.sv
// PDS link receiver: splits packet words, buffers them and counts overflow losses.
// Defining PDS_RX_FILTER_EN discards packets not addressed to MY_ADDR and counts them.
module pds_rx
  import pds_pkg::*;
#(
  parameter int             DEPTH   = 8,
  parameter logic [3:0]     MY_ADDR = 4'h0
) (
  input logic       clk,
  input logic       reset,
  pds_rx_if.slave   bus
);

  localparam int LW = $clog2(DEPTH) + 1;
`ifdef PDS_RX_FILTER_EN
  localparam logic FILTER_ON = 1'b1;
`else
  localparam logic FILTER_ON = 1'b0;
`endif

  pds_pkt_t             pkt_s, head_s;
  logic                 filt_s, push_req_s, drop_s;
  logic                 out_valid_s, full_s, empty_s;
  logic [LW-1:0]        level_s;
  logic [PDS_CNT_W-1:0] drop_cnt_r;

  assign pkt_s      = pds_pkt_t'(bus.data_ip);
  // Filter decision comes ahead of the full check so a filtered word is never a drop
  assign filt_s     = bus.valid_up & FILTER_ON & (pkt_s.target != MY_ADDR);
  assign push_req_s = bus.valid_up & ~filt_s;
  assign drop_s     = push_req_s & full_s & ~(bus.out_ready & out_valid_s);

  pds_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req_s),
    .pop   (bus.out_ready),
    .din   (pkt_s),
    .dout  (head_s),
    .valid (out_valid_s),
    .level (level_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Overflow loss counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_r <= {PDS_CNT_W{1'b0}};
    end else if (drop_s) begin
      drop_cnt_r <= sat_inc(drop_cnt_r);
    end
  end

`ifdef PDS_RX_FILTER_EN
  logic [PDS_CNT_W-1:0] filt_cnt_r;

  // Address-filter discard counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_cnt_r <= {PDS_CNT_W{1'b0}};
    end else if (filt_s) begin
      filt_cnt_r <= sat_inc(filt_cnt_r);
    end
  end

  assign bus.filt_cnt = filt_cnt_r;
`endif

  assign bus.out_valid  = out_valid_s;
  assign bus.out_source = head_s.source;
  assign bus.out_target = head_s.target;
  assign bus.out_data   = head_s.data;
  assign bus.level      = level_s;
  assign bus.full       = full_s;
  assign bus.empty      = empty_s;
  assign bus.drop_cnt   = drop_cnt_r;

endmodule

// File: tb/tb_pds_rx.sv
// Randomized and directed bench for pds_rx against a queue-based packet model.
module tb_pds_rx;
  import pds_pkg::*;

  localparam int         DEPTH   = 8;
  localparam logic [3:0] MY_ADDR = 4'h3;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  pds_rx_if #(.DEPTH(DEPTH)) bus ();

  pds_rx #(.DEPTH(DEPTH), .MY_ADDR(MY_ADDR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: packet queue, last visible head and loss counters
  pds_pkt_t    q[$];
  pds_pkt_t    exp_out;
  int unsigned m_drop;
  int unsigned m_filt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    exp_out = '0;
    m_drop  = 0;
    m_filt  = 0;
  endtask

  task automatic model_step(input logic v, input logic [15:0] d, input logic r);
    pds_pkt_t p;
    p = pds_pkt_t'(d);
    if (r && q.size() > 0) void'(q.pop_front());
    if (v) begin
`ifdef PDS_RX_FILTER_EN
      if (p.target != MY_ADDR) begin
        if (m_filt < 32'hFFFF) m_filt++;
      end else
`endif
      if (q.size() < DEPTH) q.push_back(p);
      else if (m_drop < 32'hFFFF) m_drop++;
    end
    if (q.size() > 0) exp_out = q[0];
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(q.size() > 0));
    chk({tag, ".level"}, 32'(bus.level), q.size());
    chk({tag, ".full"}, 32'(bus.full), 32'(q.size() == DEPTH));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(q.size() == 0));
    chk({tag, ".drop_cnt"}, 32'(bus.drop_cnt), m_drop);
`ifdef PDS_RX_FILTER_EN
    chk({tag, ".filt_cnt"}, 32'(bus.filt_cnt), m_filt);
`endif
    chk({tag, ".head"}, 32'({bus.out_source, bus.out_target, bus.out_data}), 32'(exp_out));
  endtask

  // Inputs change on the falling edge; outputs are compared on the next falling edge
  task automatic cycle(input string tag, input logic v, input logic [15:0] d, input logic r);
    bus.valid_up  = v;
    bus.data_ip   = d;
    bus.out_ready = r;
    @(posedge clk);
    model_step(v, d, r);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    bus.valid_up  = 1'b0;
    bus.data_ip   = 16'h0000;
    bus.out_ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1'b1;
  endtask

  function automatic logic [15:0] mk_word(input bit any_tgt);
    logic [15:0] w;
    w = 16'($urandom);
    if (!any_tgt) w[11:8] = MY_ADDR;
    return w;
  endfunction

  int rdy_pct[5] = '{20, 80, 50, 5, 95};

  initial begin
    do_reset();

    // Single packet, then pop it
    cycle("single", 1'b1, 16'h12A5, 1'b0);
    chk("single.src", 32'(bus.out_source), 32'h1);
    chk("single.tgt", 32'(bus.out_target), 32'h2);
    chk("single.data", 32'(bus.out_data), 32'hA5);
    cycle("single_pop", 1'b0, 16'h0000, 1'b1);
    chk("single_pop.empty", 32'(bus.empty), 32'h1);

    // Overflow with DEPTH+3 back-to-back pushes
    for (int i = 0; i < DEPTH + 3; i++) cycle("ovf", 1'b1, mk_word(1'b0), 1'b0);
    chk("ovf.full", 32'(bus.full), 32'h1);
    chk("ovf.level", 32'(bus.level), 32'd8);
    chk("ovf.drop", 32'(bus.drop_cnt), 32'd3);

    // Push and pop together while full, across pointer wrap
    for (int i = 0; i < 4; i++) begin
      cycle("fullpp", 1'b1, mk_word(1'b0), 1'b1);
      chk("fullpp.level", 32'(bus.level), 32'd8);
      chk("fullpp.drop", 32'(bus.drop_cnt), 32'd3);
    end
    for (int i = 0; i < DEPTH + 1; i++) cycle("drain", 1'b0, 16'h0000, 1'b1);

    // Asynchronous reset with five packets stored
    for (int i = 0; i < 5; i++) cycle("fill5", 1'b1, mk_word(1'b0), 1'b0);
    chk("fill5.level", 32'(bus.level), 32'd5);
    reset = 1'b0;
    #1;
    model_clear();
    chk("midrst.out_valid", 32'(bus.out_valid), 32'h0);
    chk("midrst.level", 32'(bus.level), 32'h0);
    chk("midrst.drop", 32'(bus.drop_cnt), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    cycle("postrst", 1'b1, 16'h53C7, 1'b0);
    chk("postrst.data", 32'(bus.out_data), 32'hC7);

    // Target filter: 3, 7, 3
    do_reset();
    cycle("filt", 1'b1, 16'h5311, 1'b0);
    cycle("filt", 1'b1, 16'h6722, 1'b0);
    cycle("filt", 1'b1, 16'h7333, 1'b0);
`ifdef PDS_RX_FILTER_EN
    chk("filt.level", 32'(bus.level), 32'd2);
    chk("filt.filt_cnt", 32'(bus.filt_cnt), 32'd1);
`else
    chk("filt.level", 32'(bus.level), 32'd3);
`endif
    chk("filt.drop", 32'(bus.drop_cnt), 32'd0);

    // Random traffic with varying downstream pressure
    do_reset();
    for (int ph = 0; ph < 5; ph++) begin
      for (int i = 0; i < 300; i++) begin
        cycle("rand", ($urandom_range(0, 3) != 0),
              mk_word(1'b1),
              ($urandom_range(0, 99) < rdy_pct[ph]));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
